// File: rtl/ifetch_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_pkg
// Shared constants and helpers for the instruction-fetch prefetch queue.
//   NOP_INST         : instruction presented to decode when the queue is empty
//   DEFAULT_RESET_PC : default fetch address after reset
//   ptr_width()      : pointer width for a power-of-two queue depth (min 1 bit)
// ----------------------------------------------------------------------------
package ifetch_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic int ptr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry FIFO holding {address, instruction} pairs for the fetch stage.
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-low reset
//   push         : write wr_data at the write pointer
//   pop          : retire the head entry
//   flush        : drop all entries (wins over push and pop)
//   wr_data      : entry to write
//   head         : entry at the read pointer (undefined when empty)
//   full, empty  : occupancy flags
//   count        : number of valid entries, 0..DEPTH
// ----------------------------------------------------------------------------
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48,
    localparam int PW   = ptr_width(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign head  = storage[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Control state: pointers wrap naturally because DEPTH is a power of two.
    // A flush empties the queue by pulling the read pointer up to the write
    // pointer, so nothing stale can be read afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Data storage carries no reset; an empty queue is masked downstream.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            storage[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
// Instruction-fetch stage with a prefetch queue. Fetches sequentially ahead of
// decode into a FIFO of {address, instruction} pairs; decode pops under stall
// control and a taken branch flushes the queue and redirects fetch.
// Ports:
//   clk, rst       : clock (rising edge), asynchronous active-low reset
//   mem_req_o      : fetch request to instruction memory
//   mem_addr_o     : fetch address (current fetch PC)
//   mem_ack_i      : memory returns mem_data_i this cycle
//   mem_data_i     : instruction word from memory
//   branch_i       : taken branch, redirect fetch to branch_addr_i
//   branch_addr_i  : branch target
//   stall_i        : decode not accepting, hold the head entry
//   inst_o         : head instruction (NOP when empty)
//   inst_addr_o    : address of inst_o (zero when empty)
//   inst_valid_o   : queue non-empty
//   pc_value_o     : current fetch PC
// ----------------------------------------------------------------------------
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int              ADDR     = 16,
    parameter int              WORD     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR-1:0] RESET_PC = ADDR'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_o,
    output logic [ADDR-1:0] mem_addr_o,
    input  logic            mem_ack_i,
    input  logic [WORD-1:0] mem_data_i,
    input  logic            branch_i,
    input  logic [ADDR-1:0] branch_addr_i,
    input  logic            stall_i,
    output logic [WORD-1:0] inst_o,
    output logic [ADDR-1:0] inst_addr_o,
    output logic            inst_valid_o,
    output logic [ADDR-1:0] pc_value_o
);

    localparam int CW = ptr_width(DEPTH) + 1;

    logic [ADDR-1:0]      fpc;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [CW-1:0]        count;
    logic [ADDR+WORD-1:0] head;

    // A branch dominates: it kills the pop, and forcing the request low makes
    // any same-cycle ack a non-transfer, so the wrong-path word is dropped.
    assign pop       = ~empty & ~stall_i & ~branch_i;
    // A full queue may still accept a word when the head leaves this cycle.
    assign mem_req_o = rst & ~branch_i & (~full | pop);
    assign push      = mem_req_o & mem_ack_i;

    assign mem_addr_o   = fpc;
    assign pc_value_o   = fpc;
    assign inst_valid_o = ~empty;
    assign inst_addr_o  = empty ? '0 : head[ADDR+WORD-1:WORD];
    assign inst_o       = empty ? WORD'(NOP_INST) : head[WORD-1:0];

    // Fetch PC: advances only on a completed transfer, so the address stays
    // put while memory holds ack low. Increment wraps mod 2^ADDR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc <= RESET_PC;
        end else if (branch_i) begin
            fpc <= branch_addr_i;
        end else if (push) begin
            fpc <= fpc + ADDR'(1);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR + WORD)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (branch_i),
        .wr_data ({fpc, mem_data_i}),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Occupancy can never exceed DEPTH, and a push into a full queue is only
    // possible together with a pop.
    always @(posedge clk) begin
        if (rst) begin
            assert (count <= CW'(DEPTH));
            assert (!(push && full && !pop));
        end
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Parametrised instruction-fetch stage with a prefetch queue. It decouples memory fetch from decode: it fetches sequentially ahead of the consumer into a DEPTH-entry FIFO of {address, instruction} pairs. Decode pops entries under stall control, and a taken branch flushes the queue and redirects fetch. It sits between instruction memory (req/ack port) and the decode stage, in the slot of the single-register fetch stage.

Parameters:
ADDR, 16, address width in bits
WORD, 32, instruction width in bits
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 0, fetch address after reset (ADDR bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active low
mem_req_o  out  1  fetch request to instruction memory
mem_addr_o  out  ADDR  fetch address; equals fpc
mem_ack_i  in  1  memory returns mem_data_i this cycle
mem_data_i  in  WORD  instruction word from memory
branch_i  in  1  redirect fetch (high = branch taken)
branch_addr_i  in  ADDR  branch target
stall_i  in  1  decode not accepting (high = hold head)
inst_o  out  WORD  head instruction to decode
inst_addr_o  out  ADDR  address of inst_o
inst_valid_o  out  1  queue non-empty, inst_o/inst_addr_o meaningful
pc_value_o  out  ADDR  current fetch PC (fpc)

Behaviour:
- Clock is clk; reset is rst, asynchronous, active low. While rst is low: fpc = RESET_PC, count = 0, read and write pointers = 0, mem_req_o = 0, inst_valid_o = 0, inst_o = 0, inst_addr_o = 0, pc_value_o = RESET_PC. An assertion mid-operation discards all queued entries and any in-flight transfer.
- State: fpc (ADDR), FIFO storage DEPTH x (ADDR+WORD), wr_ptr and rd_ptr (log2 DEPTH, wrap mod DEPTH), count (0..DEPTH).
- pop = inst_valid_o & ~stall_i & ~branch_i.
- mem_req_o = rst & ~branch_i & ((count < DEPTH) | pop). It is combinational from stall_i and branch_i by design.
- push = mem_req_o & mem_ack_i. A transfer is one cycle with both signals high. On push: write {fpc, mem_data_i} at wr_ptr, then fpc <= fpc + 1, wrapping mod 2^ADDR (all-ones wraps to 0).
- The memory may hold ack low for any number of cycles. mem_addr_o stays stable while req is high without ack, unless a branch occurs.
- Head: inst_valid_o = (count != 0). inst_o and inst_addr_o come combinationally from the rd_ptr entry. When empty, inst_o = 0 (NOP) and inst_addr_o = 0.
- Latency: an ack in cycle t makes the entry visible in cycle t+1 (inst_valid_o rises t+1 if the queue was empty). There is no bypass from mem_data_i to inst_o.
- Simultaneous push and pop: count is unchanged, both pointers advance. Push is legal at count == DEPTH only with a same-cycle pop.
- Stall: the head is held and the queue keeps filling until full. At full with stall high, mem_req_o = 0.
- Branch (highest priority, overrides stall, push and pop):
  - count <= 0 and rd_ptr <= wr_ptr.
  - fpc <= branch_addr_i.
  - Any mem_ack_i in the same cycle is ignored, because mem_req_o is forced low.
  - The target is requested at t+1 and its instruction is valid at t+2 at the earliest.
- No other states exist. The queue occupancy is the only control state, and the design has no hidden FSM.

Decomposition:
- Package ifetch_pkg: NOP_INST constant (all zeros), default RESET_PC, and a function for clog2-based pointer width.
- Sub-module fetch_fifo holds the storage, pointers and count. Its ports are push, pop, flush, full, empty, count and head data. ifetch_queue keeps fpc, the request logic and the branch/stall priority.

Test Plan:
- Reset, then ack tied high, stall low, ADDR=16 -> addresses 0,1,2,3 requested on consecutive cycles; inst_valid_o rises at cycle 1 with inst_addr_o = 0 and advances by 1 each cycle.
- stall_i high for 10 cycles with ack always high, DEPTH=4 -> exactly 4 pushes, mem_req_o = 0 at count = 4, head stays addr 0; release stall -> pops 0,1,2,3 with no gaps.
- Branch to 0x0040 with 3 entries queued and an ack in the same cycle -> inst_valid_o = 0 next cycle, mem_addr_o = 0x0040, the acked word never appears; first inst_addr_o = 0x0040 two cycles after the branch.
- mem_ack_i delayed 3 cycles per request -> mem_addr_o is stable during the wait, and each instruction appears once in order with correct addresses.
- fpc = 0xFFFF with an ack -> entry tagged 0xFFFF, next request at 0x0000.
- rst pulled low while full and stalled -> all outputs take their reset values immediately; after release, the first request is RESET_PC.
